// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg - shared parity encodings, rx FSM states and majority vote. Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// uart_rx_sampler - rx synchroniser, oversample tick counter, 2-of-3 vote. Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick_i,
  input  logic rx_i,
  input  logic run_i,
  output logic rx_s_o,
  output logic bit_o,
  output logic bit_done_o,
  output logic bit_end_o
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] C_SA  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] C_SB  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] C_SC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] C_END = TW'(OVERSAMPLE - 1);

  logic          sync1_q, sync2_q;
  logic          samp_a_q, samp_b_q;
  logic [TW-1:0] tcnt_q;
  logic          w_adv;

  assign w_adv = baud_tick_i & run_i;

  // Counter is held at 0 while idle so the first tick after start detection is tcnt=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
      tcnt_q   <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      if (!run_i)           tcnt_q <= '0;
      else if (baud_tick_i) tcnt_q <= tcnt_q + 1'b1;
      if (w_adv && tcnt_q == C_SA) samp_a_q <= sync2_q;
      if (w_adv && tcnt_q == C_SB) samp_b_q <= sync2_q;
    end
  end

  assign rx_s_o     = sync2_q;
  assign bit_o      = maj3(samp_a_q, samp_b_q, sync2_q);
  assign bit_done_o = w_adv && (tcnt_q == C_SC);
  assign bit_end_o  = w_adv && (tcnt_q == C_END);

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
// uart_rx_core - UART receiver FSM with one-entry valid/ready holding register. Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 break_det,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);
  import uart_pkg::*;

  localparam int BW = $clog2(DATA_BITS + 1);

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 scnt_q, scnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_q, par_d;
  logic                 pbit_q, pbit_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 done_q, done_d;
  logic                 brk_q, brk_d;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, hferr_q, hperr_q, ovr_q;

  logic w_rx_s, w_bit, w_bit_done, w_bit_end;
  logic w_busy, w_par_en, w_zero, w_load;

  assign w_busy = (state_q == ST_START) || (state_q == ST_DATA) ||
                  (state_q == ST_PARITY) || (state_q == ST_STOP);

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .baud_tick_i(baud_tick),
    .rx_i       (rx),
    .run_i      (w_busy),
    .rx_s_o     (w_rx_s),
    .bit_o      (w_bit),
    .bit_done_o (w_bit_done),
    .bit_end_o  (w_bit_end)
  );

  assign w_par_en = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign w_zero   = (shift_q == '0) && !(w_par_en && pbit_q);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    pbit_d  = pbit_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    brk_d   = 1'b0;
    if (!rx_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (baud_tick && !w_rx_s) begin
          state_d = ST_START;
          bcnt_d  = '0;
          scnt_d  = 1'b0;
          pbit_d  = 1'b0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
        ST_START: begin
          if (w_bit_done) begin
            if (w_bit) state_d = ST_IDLE;
            else       par_d   = parity_mode;
          end else if (w_bit_end) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            shift_d = {w_bit, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
          end else if (w_bit_end && bcnt_q == BW'(DATA_BITS)) begin
            state_d = w_par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            pbit_d = w_bit;
            perr_d = (^shift_q) ^ w_bit ^ (par_q == PAR_ODD);
          end else if (w_bit_end) begin
            state_d = ST_STOP;
          end
        end
        // The last stop bit ends at its mid-point to absorb baud skew.
        ST_STOP: if (w_bit_done) begin
          ferr_d = ferr_q | ~w_bit;
          if (scnt_q == 1'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            if (ferr_d && w_zero) begin
              brk_d   = 1'b1;
              state_d = ST_WAIT_HIGH;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            scnt_d = 1'b1;
          end
        end
        ST_WAIT_HIGH: if (baud_tick && w_rx_s) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      scnt_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= PAR_NONE;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pbit_q  <= pbit_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      brk_q   <= brk_d;
    end
  end

  // A consumer pop in the delivery cycle frees the slot for the new frame.
  assign w_load = done_q && (!valid_q || rx_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      hferr_q <= 1'b0;
      hperr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (w_load) begin
        data_q  <= shift_q;
        hferr_q <= ferr_q;
        hperr_q <= perr_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
      if (done_q && !w_load) ovr_q <= 1'b1;
      else if (clr_overrun)  ovr_q <= 1'b0;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_frame_err  = hferr_q;
  assign rx_parity_err = hperr_q;
  assign break_det     = brk_q;
  assign overrun       = ovr_q;
  assign busy          = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// tb_uart_rx_core - directed vector bench for 8N1 and 9-bit/2-stop receivers. Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

  logic       clk = 1'b0, rst = 1'b1, rx_en = 1'b1, baud_tick = 1'b0;
  logic       rxa = 1'b1, rxb = 1'b1, rx_ready = 1'b0, clr_overrun = 1'b0;
  logic [1:0] parity_mode = 2'd0;
  logic [1:0] tdiv = 2'd0;

  logic [7:0] a_data;
  logic       a_valid, a_ferr, a_perr, a_brk, a_ovr, a_busy;
  logic [8:0] b_data;
  logic       b_valid, b_ferr, b_perr, b_brk, b_ovr, b_busy;

  int nvec = 0, nmis = 0;
  int a_vcnt = 0, a_bcnt = 0, a_busyc = 0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx_en(rx_en), .baud_tick(baud_tick), .rx(rxa),
    .parity_mode(parity_mode), .rx_data(a_data), .rx_valid(a_valid), .rx_ready(rx_ready),
    .rx_frame_err(a_ferr), .rx_parity_err(a_perr), .break_det(a_brk), .overrun(a_ovr),
    .clr_overrun(clr_overrun), .busy(a_busy)
  );

  uart_rx_core #(.DATA_BITS(9), .OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rx_en(rx_en), .baud_tick(baud_tick), .rx(rxb),
    .parity_mode(parity_mode), .rx_data(b_data), .rx_valid(b_valid), .rx_ready(rx_ready),
    .rx_frame_err(b_ferr), .rx_parity_err(b_perr), .break_det(b_brk), .overrun(b_ovr),
    .clr_overrun(clr_overrun), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clocks, updated away from the active edge.
  always @(negedge clk) begin
    tdiv      <= tdiv + 2'd1;
    baud_tick <= (tdiv == 2'd0);
  end

  always @(posedge clk) begin
    if (a_valid) a_vcnt++;
    if (a_brk)   a_bcnt++;
    if (a_busy)  a_busyc++;
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       pb;
    logic       stop;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!baud_tick);
    end
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxb = v;
    else     rxa = v;
  endtask

  task automatic send_frame(input bit sel, input logic [8:0] d, input int nbits,
                            input logic [1:0] pm, input logic pb,
                            input logic [1:0] stops, input int nstop, input int gap);
    logic [13:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < nbits; i++) begin bits[n] = d[i]; n++; end
    if (pm == 2'd1 || pm == 2'd2) begin bits[n] = pb; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = stops[i]; n++; end
    parity_mode = pm;
    for (int i = 0; i < n; i++) begin
      drive(sel, bits[i]);
      tick_wait(16);
    end
    drive(sel, 1'b1);
    tick_wait(gap);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, d;
    //            data   pm     pb    stop  exp    perr  ferr
    tbl[0] = '{8'hA5, 2'd0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h37, 2'd1, 1'b0, 1'b1, 8'h37, 1'b1, 1'b0};
    tbl[2] = '{8'h37, 2'd2, 1'b0, 1'b1, 8'h37, 1'b0, 1'b0};
    tbl[3] = '{8'h37, 2'd1, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 2'd2, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h5A, 2'd3, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    tbl[7] = '{8'h81, 2'd2, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    tbl[8] = '{8'hC3, 2'd1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

    repeat (5) @(posedge clk);
    #1;
    chk("reset a_valid", 32'(a_valid), 0);
    chk("reset a_data",  32'(a_data),  0);
    chk("reset a_busy",  32'(a_busy),  0);
    chk("reset a_ovr",   32'(a_ovr),   0);
    chk("reset b_valid", 32'(b_valid), 0);
    chk("reset b_data",  32'(b_data),  0);
    rst = 1'b0;
    tick_wait(4);

    // 8N1 0xA5 with the consumer always ready; busy must fall at the stop mid-point
    rx_ready = 1'b1;
    snap = a_vcnt;
    parity_mode = 2'd0;
    drive(0, 1'b0); tick_wait(16);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a5;
      a5 = 8'hA5;
      drive(0, a5[i]); tick_wait(16);
    end
    drive(0, 1'b1);
    tick_wait(10);
    chk("a5 busy before stop mid", 32'(a_busy), 1);
    tick_wait(1);
    chk("a5 busy after stop mid", 32'(a_busy), 0);
    tick_wait(10);
    chk("a5 valid pulses", 32'(a_vcnt - snap), 1);
    chk("a5 data", 32'(a_data), 32'h A5);
    chk("a5 perr", 32'(a_perr), 0);
    chk("a5 ferr", 32'(a_ferr), 0);
    chk("a5 valid dropped", 32'(a_valid), 0);
    rx_ready = 1'b0;

    for (int i = 0; i < 9; i++) begin
      send_frame(0, {1'b0, tbl[i].d}, 8, tbl[i].pm, tbl[i].pb, {1'b1, tbl[i].stop}, 1, 20);
      chk($sformatf("vec%0d valid", i), 32'(a_valid), 1);
      chk($sformatf("vec%0d data", i),  32'(a_data),  32'(tbl[i].ed));
      chk($sformatf("vec%0d perr", i),  32'(a_perr),  32'(tbl[i].ep));
      chk($sformatf("vec%0d ferr", i),  32'(a_ferr),  32'(tbl[i].ef));
      consume();
      chk($sformatf("vec%0d consumed", i), 32'(a_valid), 0);
    end

    // 3-tick glitch is a false start
    parity_mode = 2'd0;
    snap = a_busyc;
    drive(0, 1'b0); tick_wait(3);
    drive(0, 1'b1); tick_wait(16);
    d = a_busyc - snap;
    chk("glitch busy span", 32'((d > 0) && (d <= 48)), 1);
    chk("glitch busy low", 32'(a_busy), 0);
    chk("glitch no frame", 32'(a_valid), 0);

    // rx_en drop mid-frame aborts without delivery
    drive(0, 1'b0); tick_wait(40);
    chk("abort busy before", 32'(a_busy), 1);
    rx_en = 1'b0;
    @(posedge clk); #1;
    chk("abort busy after", 32'(a_busy), 0);
    rx_en = 1'b1;
    drive(0, 1'b1); tick_wait(200);
    chk("abort no frame", 32'(a_valid), 0);

    // overrun with consumer stalled, then clear
    send_frame(0, 9'h011, 8, 2'd0, 1'b0, 2'b11, 1, 20);
    send_frame(0, 9'h022, 8, 2'd0, 1'b0, 2'b11, 1, 20);
    chk("ovr data kept", 32'(a_data), 32'h11);
    chk("ovr valid", 32'(a_valid), 1);
    chk("ovr set", 32'(a_ovr), 1);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    clr_overrun = 1'b0;
    chk("ovr cleared", 32'(a_ovr), 0);
    chk("ovr entry remains", 32'(a_valid), 1);
    chk("ovr entry data", 32'(a_data), 32'h11);
    consume();

    // break: line low for two frame times
    snap = a_bcnt;
    drive(0, 1'b0); tick_wait(320);
    chk("brk pulses", 32'(a_bcnt - snap), 1);
    chk("brk valid", 32'(a_valid), 1);
    chk("brk data", 32'(a_data), 0);
    chk("brk ferr", 32'(a_ferr), 1);
    chk("brk busy", 32'(a_busy), 0);
    consume();
    tick_wait(32);
    chk("brk no new frame", 32'(a_valid), 0);
    chk("brk still idle", 32'(a_busy), 0);
    drive(0, 1'b1); tick_wait(20);
    send_frame(0, 9'h03C, 8, 2'd0, 1'b0, 2'b11, 1, 20);
    chk("post brk valid", 32'(a_valid), 1);
    chk("post brk data", 32'(a_data), 32'h3C);
    chk("post brk ferr", 32'(a_ferr), 0);
    consume();

    // 9 data bits, 2 stop bits
    send_frame(1, 9'h1C3, 9, 2'd0, 1'b0, 2'b11, 2, 20);
    chk("b valid", 32'(b_valid), 1);
    chk("b data", 32'(b_data), 32'h1C3);
    chk("b ferr", 32'(b_ferr), 0);
    consume();
    send_frame(1, 9'h1C3, 9, 2'd0, 1'b0, 2'b01, 2, 20);
    chk("b stop2 data", 32'(b_data), 32'h1C3);
    chk("b stop2 ferr", 32'(b_ferr), 1);
    chk("b stop2 no brk", 32'(b_brk), 0);

    // reset in the middle of data bits with an entry pending
    drive(1, 1'b0); tick_wait(16);
    drive(1, 1'b1); tick_wait(16);
    drive(1, 1'b1); tick_wait(16);
    drive(1, 1'b0); tick_wait(8);
    chk("b busy mid", 32'(b_busy), 1);
    chk("b pending", 32'(b_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("b rst data",  32'(b_data),  0);
    chk("b rst valid", 32'(b_valid), 0);
    chk("b rst ferr",  32'(b_ferr),  0);
    chk("b rst perr",  32'(b_perr),  0);
    chk("b rst brk",   32'(b_brk),   0);
    chk("b rst ovr",   32'(b_ovr),   0);
    chk("b rst busy",  32'(b_busy),  0);
    rst = 1'b0;
    drive(1, 1'b1);
    tick_wait(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire
